// File: rtl/flash_pkg.sv
// Shared types and helpers for the LED flash burst generator.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package flash_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } flash_state_t;

    // Timer width that can hold max(on_cyc, off_cyc) - 1. Never less than one bit.
    function automatic int timer_w(input int on_cyc, input int off_cyc);
        int mx;
        int w;
        mx = (on_cyc > off_cyc) ? on_cyc : off_cyc;
        w  = $clog2(mx);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/flash_gen_if.sv
// Request/complete bundle between a controller and the flash burst generator.
// Latency: none (wiring only).
// Backpressure: none. The controller watches busy and done.
// Ports: start, n_flash, abort (controller -> generator); ld, busy, done (generator -> controller).
interface flash_gen_if #(
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] n_flash;
    logic             abort;
    logic             ld;
    logic             busy;
    logic             done;

    modport master (
        output start, n_flash, abort,
        input  ld, busy, done
    );

    modport slave (
        input  start, n_flash, abort,
        output ld, busy, done
    );
endinterface

// File: rtl/flash_timer.sv
// Loadable down-counter that times the ON and OFF phases of a flash.
// Latency: load and decrement take effect at the next clock; zero is combinational from the count.
// Backpressure: none. It holds at zero when dec is set and the count is already zero.
// Ports: clk, rst (sync, active-high), load_i/load_val_i, dec_i, zero_o.
module flash_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/flash_gen.sv
// Drives the LED with a burst of n_flash timed flashes per start request.
// Latency: ld and busy rise one clock after start is accepted; done pulses one clock after the last OFF phase.
// Backpressure: start is sampled only in IDLE. A start seen while busy is dropped, not queued.
// Ports: clk, rst (sync, active-high), bus (slave: start, n_flash, abort in; ld, busy, done out).
module flash_gen
    import flash_pkg::*;
#(
    parameter int ON_CYC  = 16,
    parameter int OFF_CYC = 16,
    parameter int CNT_W   = 4
) (
    input  logic         clk,
    input  logic         rst,
    flash_gen_if.slave   bus
);
    localparam int TW = timer_w(ON_CYC, OFF_CYC);
    localparam logic [TW-1:0] ON_LD  = TW'(ON_CYC - 1);
    localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYC - 1);

    flash_state_t      state_q;
    logic [CNT_W-1:0]  rem_q;
    logic              ld_q;
    logic              busy_q;
    logic              done_q;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_dec;
    logic              tmr_zero;

    logic              accept;
    logic              last_flash;

    assign accept     = bus.start && !bus.abort && (bus.n_flash != '0);
    assign last_flash = (rem_q == CNT_W'(1));

    // Timer control follows the current state. abort reloads zero so the counter
    // sits idle in a known value.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    tmr_load = 1'b1;
                    tmr_val  = ON_LD;
                end
            end
            ON: begin
                if (bus.abort) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            OFF: begin
                if (bus.abort) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = last_flash ? '0 : ON_LD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                tmr_load = 1'b1;
            end
        endcase
    end

    flash_timer #(.W(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // The outputs are registered alongside the state. Each transition sets the
    // value the outputs must hold in the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            ld_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // If abort arrives with start, abort wins and the start is dropped.
                    if (bus.start && !bus.abort) begin
                        if (bus.n_flash != '0) begin
                            rem_q   <= bus.n_flash;
                            state_q <= ON;
                            ld_q    <= 1'b1;
                            busy_q  <= 1'b1;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        rem_q   <= '0;
                        ld_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (tmr_zero) begin
                        state_q <= OFF;
                        ld_q    <= 1'b0;
                    end
                end
                OFF: begin
                    if (bus.abort) begin
                        state_q <= IDLE;
                        rem_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (tmr_zero) begin
                        rem_q <= rem_q - CNT_W'(1);
                        if (last_flash) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ON;
                            ld_q    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    rem_q   <= '0;
                    ld_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ld   = ld_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_flash_gen.sv
// Bench for flash_gen. It uses directed scenarios followed by random requests.
// Each output is compared against a burst-schedule model after every clock edge.
module tb_flash_gen;
    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int P   = ON + OFF;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   cyc;

    // The model tracks the edge at which the current burst was accepted and its flash count.
    bit   m_valid;
    int   m_t0;
    int   m_n;

    flash_gen_if #(.CNT_W(4)) bus ();

    flash_gen #(.ON_CYC(ON), .OFF_CYC(OFF), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit m_active_before(input int e);
        int ph;
        ph = (e - 1) - m_t0;
        return m_valid && (ph >= 0) && (ph < m_n * P);
    endfunction

    function automatic bit exp_ld();
        int ph;
        ph = cyc - m_t0;
        return m_valid && (ph < m_n * P) && ((ph % P) < ON);
    endfunction

    function automatic bit exp_busy();
        return m_valid && ((cyc - m_t0) < m_n * P);
    endfunction

    function automatic bit exp_done();
        return m_valid && ((cyc - m_t0) == m_n * P);
    endfunction

    // Applies one cycle of inputs, clocks once, updates the model and checks all outputs.
    task automatic step(input bit s, input int n, input bit a, input bit r);
        bit act;
        bus.start   = s;
        bus.n_flash = 4'(n);
        bus.abort   = a;
        rst         = r;
        @(posedge clk);
        cyc++;
        act = m_active_before(cyc);
        if (r) begin
            m_valid = 1'b0;
        end else if (a) begin
            if (act) m_valid = 1'b0;
        end else if (s && !act) begin
            m_valid = 1'b1;
            m_t0    = cyc;
            m_n     = n;
        end
        #1;
        chk("ld",   32'(bus.ld),   32'(exp_ld()));
        chk("busy", 32'(bus.busy), 32'(exp_busy()));
        chk("done", 32'(bus.done), 32'(exp_done()));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [10:0] t1_ld;
        logic [10:0] t1_busy;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        m_valid  = 1'b0;
        m_t0     = 0;
        m_n      = 0;
        bus.start   = 1'b0;
        bus.n_flash = '0;
        bus.abort   = 1'b0;
        rst         = 1'b1;

        // Reset state
        step(1'b1, 3, 1'b0, 1'b1);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("rst_ld",   32'(bus.ld),   32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        idle(2);

        // T1: two flashes. Checked against fixed waveforms as well as the model.
        // Bit k is the value after the k-th edge following acceptance.
        t1_ld   = 11'b00011100111;
        t1_busy = 11'b01111111111;
        step(1'b1, 2, 1'b0, 1'b0);
        chk("t1_ld",   32'(bus.ld),   32'(t1_ld[0]));
        chk("t1_busy", 32'(bus.busy), 32'(t1_busy[0]));
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 0, 1'b0, 1'b0);
            chk("t1_ld",   32'(bus.ld),   32'(t1_ld[k]));
            chk("t1_busy", 32'(bus.busy), 32'(t1_busy[k]));
            chk("t1_done", 32'(bus.done), 32'(k == 10));
        end
        idle(3);

        // T2: n_flash == 0
        step(1'b1, 0, 1'b0, 1'b0);
        chk("t2_done", 32'(bus.done), 32'd1);
        chk("t2_busy", 32'(bus.busy), 32'd0);
        idle(3);

        // T3: start while busy is ignored
        step(1'b1, 1, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 5, 1'b0, 1'b0);
        idle(12);

        // T4: abort while in ON
        step(1'b1, 3, 1'b0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        chk("t4_ld",   32'(bus.ld),   32'd0);
        chk("t4_busy", 32'(bus.busy), 32'd0);
        idle(16);

        // T5: reset in the middle of a long burst, then restart
        step(1'b1, 15, 1'b0, 1'b0);
        idle(19);
        step(1'b0, 0, 1'b0, 1'b1);
        chk("t5_ld",   32'(bus.ld),   32'd0);
        chk("t5_busy", 32'(bus.busy), 32'd0);
        step(1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1, 1'b0, 1'b0);
        chk("t5_restart", 32'(bus.ld), 32'd1);
        idle(6);

        // T6: start in the done cycle, with no gap
        step(1'b1, 1, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 0, 1'b0, 1'b0);
        chk("t6_done", 32'(bus.done), 32'd1);
        step(1'b1, 1, 1'b0, 1'b0);
        chk("t6_ld", 32'(bus.ld), 32'd1);
        idle(6);

        // Abort together with start in IDLE drops the start
        step(1'b1, 2, 1'b1, 1'b0);
        chk("abort_start", 32'(bus.busy), 32'd0);
        idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit s;
            bit a;
            bit r;
            int n;
            s = ($urandom_range(0, 5) == 0);
            a = ($urandom_range(0, 59) == 0);
            r = ($urandom_range(0, 299) == 0);
            n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            step(s, n, a, r);
        end
        idle(80);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
